// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (inst + PC) with valid/ready, flush, sticky halt, stall counter.
// Define PIPE_STAGE_SKID_EN for a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       PC_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h6800_0000),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LD_HOLD = 2'd0,
        LD_IN   = 2'd1,
        LD_SKID = 2'd2,
        LD_NOP  = 2'd3
    } main_ld_t;

    state_t           state_q;
    state_t           state_d;
    main_ld_t         main_ld;
    logic             skid_ld;
    logic             out_valid_d;
    logic             halted_d;
    logic [CNT_W-1:0] stall_d;
    logic             acc;
    logic             dlv;

    assign acc = in_valid && in_ready;
    assign dlv = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              in_ready_q;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;

    // Registered ready; flush still squashes the accept in its own cycle
    assign in_ready = in_ready_q && !flush;
`else
    assign in_ready = !halted && !flush && (!out_valid || out_ready);
`endif

    // State register and control flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= out_valid_d;
            halted    <= halted_d;
            stall_cnt <= stall_d;
        end
    end

    // Next state, register load selects, halt and stall bookkeeping
    always_comb begin
        state_d  = state_q;
        main_ld  = LD_HOLD;
        skid_ld  = 1'b0;
        halted_d = halted;
        stall_d  = stall_cnt;

        if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_d = stall_cnt + CNT_W'(1);
        end
        if (acc && halt) begin
            halted_d = 1'b1;
        end

        if (flush) begin
            state_d = ST_EMPTY;
            main_ld = LD_NOP;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d = ST_FULL;
                        main_ld = LD_IN;
                    end
                end
                ST_FULL: begin
                    if (acc && dlv) begin
                        main_ld = LD_IN;
                    end else if (dlv) begin
                        state_d = ST_EMPTY;
                        main_ld = LD_NOP;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (acc) begin
                        state_d = ST_SKID;
                        skid_ld = 1'b1;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    if (dlv) begin
                        state_d = ST_FULL;
                        main_ld = LD_SKID;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                    main_ld = LD_NOP;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
    end

    // Main output register; pc_out deliberately holds when the stage empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_out <= NOP_INST;
            pc_out   <= '0;
        end else begin
            case (main_ld)
                LD_IN: begin
                    inst_out <= inst_in;
                    pc_out   <= pc_in;
                end
`ifdef PIPE_STAGE_SKID_EN
                LD_SKID: begin
                    inst_out <= skid_inst;
                    pc_out   <= skid_pc;
                end
`endif
                LD_NOP: begin
                    inst_out <= NOP_INST;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry and registered ready, derived from next-cycle occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_inst  <= '0;
            skid_pc    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (skid_ld) begin
                skid_inst <= inst_in;
                skid_pc   <= pc_in;
            end
            in_ready_q <= !halted_d && (state_d != ST_SKID);
        end
    end
`endif

    // Simulation-only protocol properties
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> ($stable(inst_out) && $stable(pc_out) && out_valid));

    a_halt_sticky: assert property (@(posedge clk) disable iff (rst)
        halted |=> halted);

    a_flush_blocks: assert property (@(posedge clk) disable iff (rst)
        flush |-> !in_ready);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic        halt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        halted;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_inst_out;
    logic [31:0] s_pc_out;
    logic        s_halted;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int passed = 0;

    pipe_stage_reg u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst_in(inst_in), .pc_in(pc_in), .halt(halt), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .inst_out(inst_out),
        .pc_out(pc_out), .halted(halted), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .inst_in(inst_in), .pc_in(pc_in), .halt(halt), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .inst_out(s_inst_out),
        .pc_out(s_pc_out), .halted(s_halted), .stall_cnt(s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: a FIFO of in-flight beats with capacity 1 (2 with skid)
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } beat_t;

    beat_t       mq[$];
    bit          m_halted;
    int unsigned m_cnt;
    int unsigned m_sat;
    logic [31:0] m_last_pc;

    function automatic bit m_ready();
        if (m_halted || flush) return 1'b0;
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_halted  = 1'b0;
            m_cnt     = 0;
            m_sat     = 0;
            m_last_pc = '0;
        end else begin
            bit    m_acc;
            bit    m_dlv;
            beat_t b;
            m_acc = in_valid && m_ready();
            m_dlv = (mq.size() > 0) && out_ready;
            if ((mq.size() > 0) && !out_ready) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_sat < 15) m_sat++;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (m_dlv) void'(mq.pop_front());
                if (m_acc) begin
                    b.inst = inst_in;
                    b.pc   = pc_in;
                    mq.push_back(b);
                    if (halt) m_halted = 1'b1;
                end
            end
            if (mq.size() > 0) m_last_pc = mq[0].pc;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; halt = 1'b0; flush = 1'b0; out_ready = 1'b1;
        inst_in = '0; pc_in = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 1'b1; inst_in = 32'hB0; pc_in = 32'h10; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", out_valid); else passed++;
        checks++; if (inst_out !== NOP) $display("FAIL rst_inst got %h exp %h", inst_out, NOP); else passed++;
        checks++; if (pc_out !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc_out); else passed++;
        checks++; if (stall_cnt !== 16'd0) $display("FAIL rst_stall got %0d exp 0", stall_cnt); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %0b exp 1", in_ready); else passed++;
        checks++; if (halted !== 1'b0) $display("FAIL rst_halted got %0b exp 0", halted); else passed++;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; inst_in = 32'hB1; pc_in = 32'h20; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || inst_out !== 32'hB1) $display("FAIL rst_first_acc got v=%0b i=%h exp v=1 i=b1", out_valid, inst_out); else passed++;
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                in_valid = 1'b1; inst_in = 32'hA0 + 32'(k); pc_in = 32'(k);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL stream_ready%0d got %0b exp 1", k, in_ready); else passed++;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || inst_out !== 32'hA0 + 32'(k) || pc_out !== 32'(k))
                $display("FAIL stream_beat%0d got v=%0b i=%h p=%h exp v=1 i=%h p=%h", k, out_valid, inst_out, pc_out, 32'hA0 + 32'(k), k);
            else passed++;
            if (k == 7) break;
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || inst_out !== NOP || pc_out !== 32'd7) $display("FAIL stream_drain got v=%0b i=%h p=%h exp v=0 i=%h p=7", out_valid, inst_out, pc_out, NOP); else passed++;
        checks++; if (stall_cnt !== 16'd0) $display("FAIL stream_stall got %0d exp 0", stall_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; inst_in = 32'h11; pc_in = 32'h11; out_ready = 1'b0;
        @(negedge clk);
        inst_in = 32'h22; pc_in = 32'h22;
        #1;
        checks++; if (inst_out !== 32'h11 || out_valid !== 1'b1) $display("FAIL bp_first got v=%0b i=%h exp v=1 i=11", out_valid, inst_out); else passed++;
        checks++; if (in_ready !== SKID) $display("FAIL bp_extra_ready got %0b exp %0b", in_ready, SKID); else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_low got %0b exp 0", in_ready); else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++; if (inst_out !== 32'h11 || pc_out !== 32'h11 || out_valid !== 1'b1) $display("FAIL bp_hold%0d got v=%0b i=%h p=%h exp v=1 i=11 p=11", k, out_valid, inst_out, pc_out); else passed++;
        end
        checks++; if (stall_cnt !== 16'd5) $display("FAIL bp_stall got %0d exp 5", stall_cnt); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (SKID ? (out_valid !== 1'b1 || inst_out !== 32'h22 || pc_out !== 32'h22)
                 : (out_valid !== 1'b0 || inst_out !== NOP || pc_out !== 32'h11))
            $display("FAIL bp_release got v=%0b i=%h p=%h exp skid=%0b", out_valid, inst_out, pc_out, SKID);
        else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %0b exp 1", in_ready); else passed++;
        checks++; if (stall_cnt !== 16'd5) $display("FAIL bp_stall_after got %0d exp 5", stall_cnt); else passed++;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; inst_in = 32'h44; pc_in = 32'h44; out_ready = 1'b0;
        @(negedge clk);
        inst_in = 32'h55; pc_in = 32'h55;
        @(negedge clk);
        flush = 1'b1; inst_in = 32'h66; pc_in = 32'h66; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %0b exp 0", in_ready); else passed++;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || inst_out !== NOP || pc_out !== 32'h44) $display("FAIL flush_out got v=%0b i=%h p=%h exp v=0 i=%h p=44", out_valid, inst_out, pc_out, NOP); else passed++;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || inst_out !== NOP) $display("FAIL flush_skid_gone got v=%0b i=%h exp v=0", out_valid, inst_out); else passed++;
        checks++; if (in_ready !== 1'b1 || halted !== 1'b0) $display("FAIL flush_recover got r=%0b h=%0b exp r=1 h=0", in_ready, halted); else passed++;
    endtask

    task automatic test_halt();
        do_reset();
        in_valid = 1'b1; inst_in = 32'h33; pc_in = 32'h33; halt = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        halt = 1'b0; inst_in = 32'h34; pc_in = 32'h34;
        #1;
        checks++; if (out_valid !== 1'b1 || inst_out !== 32'h33) $display("FAIL halt_deliver got v=%0b i=%h exp v=1 i=33", out_valid, inst_out); else passed++;
        checks++; if (halted !== 1'b1) $display("FAIL halt_flag got %0b exp 1", halted); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL halt_ready got %0b exp 0", in_ready); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            flush = (k != 1);
            #1;
            checks++; if (in_ready !== 1'b0 || halted !== 1'b1 || out_valid !== 1'b0) $display("FAIL halt_hold%0d got r=%0b h=%0b v=%0b exp r=0 h=1 v=0", k, in_ready, halted, out_valid); else passed++;
        end
        do_reset();
        #1;
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1) $display("FAIL halt_cleared got h=%0b r=%0b exp h=0 r=1", halted, in_ready); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; inst_in = 32'h77; pc_in = 32'h77; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) @(negedge clk);
        #1;
        checks++; if (s_stall_cnt !== 4'd15) $display("FAIL sat_value got %0d exp 15", s_stall_cnt); else passed++;
        checks++; if (stall_cnt !== 16'd20) $display("FAIL sat_wide got %0d exp 20", stall_cnt); else passed++;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd23) $display("FAIL sat_hold got %0d/%0d exp 15/23", s_stall_cnt, stall_cnt); else passed++;
    endtask

    task automatic test_random();
        int halted_cycles = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (halted_cycles > 8) begin
                rst = 1'b1;
                halted_cycles = 0;
            end else begin
                rst = 1'b0;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            halt      = ($urandom_range(0, 49) == 0);
            inst_in   = $urandom;
            pc_in     = $urandom;
            #1;
            checks++; if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_valid@%0d got %0b exp %0b", i, out_valid, mq.size() > 0); else passed++;
            checks++; if (inst_out !== ((mq.size() > 0) ? mq[0].inst : NOP)) $display("FAIL rnd_inst@%0d got %h exp %h", i, inst_out, (mq.size() > 0) ? mq[0].inst : NOP); else passed++;
            checks++; if (pc_out !== m_last_pc) $display("FAIL rnd_pc@%0d got %h exp %h", i, pc_out, m_last_pc); else passed++;
            checks++; if (in_ready !== m_ready()) $display("FAIL rnd_ready@%0d got %0b exp %0b", i, in_ready, m_ready()); else passed++;
            checks++; if (halted !== m_halted) $display("FAIL rnd_halted@%0d got %0b exp %0b", i, halted, m_halted); else passed++;
            checks++; if (stall_cnt !== 16'(m_cnt) || s_stall_cnt !== 4'(m_sat)) $display("FAIL rnd_stall@%0d got %0d/%0d exp %0d/%0d", i, stall_cnt, s_stall_cnt, m_cnt, m_sat); else passed++;
            if (m_halted) halted_cycles++;
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; halt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; halt = 1'b0; flush = 1'b0; out_ready = 1'b1;
        inst_in = '0; pc_in = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_halt();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the SimpleRISC core, the successor to the fixed 32-bit IF/OF latch. It is used between any two stages (IF/OF, OF/EX, EX/MA, MA/RW) and carries an instruction word plus PC with a valid/ready handshake. It adds synchronous flush with NOP injection, a sticky halt, and a saturating stall counter. An optional skid buffer gives a fully registered `in_ready`.

## Interface

Parameters:
- `INST_W`, 32: instruction word width.
- `PC_W`, 32: PC width.
- `NOP_INST`, 32'h6800_0000: word driven on `inst_out` when the stage is empty (SimpleRISC `nop`).
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream beat present.
- `in_ready` output 1: stage accepts a beat this cycle.
- `inst_in` input INST_W: upstream instruction.
- `pc_in` input PC_W: upstream PC.
- `halt` input 1: sampled with an accepted beat; marks that beat as the last one.
- `flush` input 1: synchronous squash of stage contents.
- `out_valid` output 1: downstream beat present.
- `out_ready` input 1: downstream accepts; a low value stalls the stage.
- `inst_out` output INST_W: registered instruction.
- `pc_out` output PC_W: registered PC.
- `halted` output 1: sticky halt flag.
- `stall_cnt` output CNT_W: saturating count of stalled cycles.

## Operation

- Accept: `acc = in_valid && in_ready`. Deliver: `dlv = out_valid && out_ready`.
- Main register states:
  - EMPTY: `out_valid=0`, `inst_out=NOP_INST`.
  - FULL: `out_valid=1`.
  - Transitions:
    - EMPTY→FULL on `acc`.
    - FULL→FULL on `acc && dlv` (new beat replaces old).
    - FULL→EMPTY on `dlv && !acc`.
    - FULL holds on `!dlv`.
  - On FULL→EMPTY, `inst_out` loads NOP_INST and `pc_out` holds its last value.
- `in_ready` without skid: combinational, `!halted && !flush && (!out_valid || out_ready)`.
- Halt:
  - `acc && halt` sets `halted` next cycle.
  - Once set, `in_ready=0` until `rst`.
  - The halting beat itself is still delivered normally.
  - `flush` does not clear `halted`.
- Flush:
  - Next cycle, `out_valid=0`, `inst_out=NOP_INST`, and any skid entry is discarded.
  - `in_ready=0` during the flush cycle, so no beat is accepted.
  - `flush` overrides a simultaneous `dlv` and `acc`.
- Stall counter:
  - Increments each cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by `rst`.
- Data never reorders. There is no combinational path from `inst_in`/`pc_in` to the outputs.

## Timing

- Latency is 1 cycle from `acc` to `out_valid`. Throughput is 1 beat/cycle when `out_ready=1`.
- Reset values:
  - `out_valid=0`, `inst_out=NOP_INST`, `pc_out=0`.
  - `halted=0`, `stall_cnt=0`.
  - `in_ready=1`; skid empty.
- `rst` mid-operation drops all beats immediately (asynchronous). The first accept is possible on the first `clk` edge after `rst` falls.
- `out_ready` may toggle freely. `inst_out`/`pc_out` must stay stable while `out_valid && !out_ready`.

## Configuration

- `PIPE_STAGE_SKID_EN` defined:
  - Adds a one-entry skid register.
  - `in_ready` is a flop: `!halted && !skid_valid`, with `flush` still gating it combinationally.
  - An accept while FULL and `!out_ready` writes the skid entry.
  - On the next `dlv`, the skid entry moves to the main register; `in_ready` returns to 1 the following cycle.
  - Capacity is 2 beats, and `in_ready` has no combinational dependence on `out_ready`.
- Not defined:
  - No skid register.
  - `in_ready` is combinational as stated in Operation.
  - Capacity is 1 beat.

## Test plan

- **Reset:** assert `rst` mid-transfer. Required: `out_valid=0`, `inst_out=32'h6800_0000`, `pc_out=0`, `stall_cnt=0`, `in_ready=1` asynchronously.
- **Streaming:** send beats inst=0xA0..0xA7, pc=0..7, with `out_ready=1`. Required: each appears 1 cycle later in order, 8 beats in 8 cycles, `stall_cnt=0`.
- **Backpressure:** hold `out_ready=0` for 5 cycles with beat 0x11 FULL. Required: outputs hold 0x11, `stall_cnt=5`. With skid, one extra beat 0x22 is accepted, then `in_ready=0`; on release, 0x11 is delivered then 0x22.
- **Flush:** assert `flush` with `in_valid=1`, `out_ready=1`. Required: the input beat is not accepted, the next cycle has `out_valid=0` and `inst_out=NOP_INST`, and the skid entry is discarded.
- **Halt:** accept beat 0x33 with `halt=1`. Required: 0x33 is delivered, `halted=1`, and `in_ready` stays 0 across later `flush` pulses until `rst`.
- **Saturation:** use `CNT_W=4` and stall 20 cycles. Required: `stall_cnt=15` and it holds.
